instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer side of the instruction memory. Today the processor only ever reads that memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses starting at 0.
- Validates the load with an XOR checksum.
- Holds the processor in reset until a load completes cleanly, then releases it to run the loaded program.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory; capacity = 2**ADDR_W words.
- WORD_W, 32, instruction width; fixed at 32, exposed for the package only.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  byte available on in_data.
- in_ready  out  1  loader can accept a byte; a transfer happens when in_valid && in_ready on a rising edge.
- in_data  in  8  stream byte.
- start  in  1  one-cycle pulse; restarts a load from DONE or ERROR.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for mem_we.
- mem_wdata  out  32  word for mem_we.
- cpu_reset  out  1  active-high reset to the processor.
- done  out  1  load completed, checksum good.
- error  out  1  load aborted (overflow or bad checksum).

Behaviour:
- Stream format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then 4*N data bytes (each word MSB first), then one CHECK byte.
- CHECK must equal the XOR of every preceding byte, including both count bytes.
- Reset (reset==0 at a clock edge) sets: state=S_CNT_HI, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, word counter=0, byte index=0, running XOR=0.
- in_ready is 1 in S_CNT_HI, S_CNT_LO, S_DATA and S_CHECK. It is 0 in S_DONE and S_ERROR, and 0 in the first cycle after reset is released.
- States and transitions:
  - S_CNT_HI: accept byte -> S_CNT_LO.
  - S_CNT_LO: accept byte.
    - N > 2**ADDR_W -> S_ERROR.
    - N == 0 -> S_CHECK.
    - else -> S_DATA.
  - S_DATA: accept bytes into a shift register. On the 4th byte of a word, the next cycle drives mem_we=1 for exactly one cycle, with mem_addr = word counter and mem_wdata = assembled word. Write latency is 1 cycle after the last byte handshake. After word N-1 is accepted -> S_CHECK.
  - S_CHECK: accept byte.
    - byte == running XOR -> S_DONE.
    - else -> S_ERROR.
  - S_DONE: done=1, cpu_reset=0 (registered; both change the cycle after S_DONE is entered). start -> S_CNT_HI.
  - S_ERROR: error=1, cpu_reset=1. start -> S_CNT_HI.
- On the start transition, the block clears done, error, counters and XOR, and drives cpu_reset=1.
- start is ignored in every state other than S_DONE and S_ERROR.
- Backpressure and gaps: in_valid may drop at any point; the state holds; no timeout.
- A CHECK byte accepted in the same cycle as the final mem_we is legal. The final write still completes before done asserts.
- The word counter is ADDR_W+1 bits, so N = 2**ADDR_W is legal. mem_addr never wraps within a legal load.
- Writes already issued before an ERROR are not undone; cpu_reset stays 1.
- Reset mid-load aborts immediately to the reset values above. A partially transferred word is never written.

Decomposition:
- Shared package loader_pkg holds:
  - state enum: S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK, S_DONE, S_ERROR;
  - BYTES_PER_WORD=4;
  - WORD_W=32.
- One natural sub-module: byte_assembler.
  - Contents: 2-bit byte index plus a 32-bit shift register.
  - Outputs: a word plus a one-cycle word_valid.
  - Reset: clear on reset or start.
- The FSM, counters and XOR stay in instr_loader.

Test Plan:
- Basic load: stream 00 01 20 08 00 05 2C, in_valid held high -> exactly one mem_we with addr 0, data 0x20080005; then done=1, cpu_reset=0, error=0, in_ready=0.
- Bad checksum: stream 00 02 00 00 00 00 FF FF FF FF 03 (correct XOR is 02) -> writes addr 0 = 0x00000000 and addr 1 = 0xFFFFFFFF; then error=1, done=0, cpu_reset stays 1.
- Empty and overflow:
  - Stream 00 00 00 -> done=1 with zero mem_we pulses.
  - Stream 01 01 (N=257, ADDR_W=8) -> error=1 immediately after the second byte, in_ready=0, no writes.
- Backpressure: repeat the basic load with in_valid deasserted for 3 cycles between every byte -> identical writes and final state; mem_we still exactly one cycle wide.
- Reset and restart:
  - Pull reset low after the 2nd data byte of word 0, then reissue the basic load -> no write from the aborted stream; clean single write to addr 0.
  - From done, pulse start -> cpu_reset=1, done=0, in_ready=1 the next cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    // States in which the loader is consuming stream bytes.
    function automatic logic is_loading(state_t s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream MSB-first into words; flags each completed word for one cycle.
module byte_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        din,
    output logic [1:0]        idx,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    import loader_pkg::*;

    logic [WORD_W-1:0] shift_p0;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            idx        <= '0;
            shift_p0   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (en) begin
                shift_p0 <= {shift_p0[WORD_W-9:0], din};
                idx      <= idx + 2'd1;
                // Last byte of the word: publish the full word on the next cycle.
                if (idx == 2'(BYTES_PER_WORD - 1)) begin
                    word       <= {shift_p0[WORD_W-9:0], din};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Fills instruction memory from a counted, XOR-checked byte stream and
// holds the processor in reset until a load completes cleanly.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    import loader_pkg::*;

    localparam int unsigned CAP = 2 ** ADDR_W;

    state_t            state;
    logic [7:0]        cnt_hi;
    logic [15:0]       n_words;
    logic [ADDR_W:0]   wcnt;
    logic [7:0]        xsum;
    logic              xfer;
    logic              restart;
    logic              asm_en;
    logic [1:0]        asm_idx;
    logic [WORD_W-1:0] asm_word;
    logic              asm_vld;

    assign xfer    = in_valid && in_ready;
    assign restart = start && ((state == S_DONE) || (state == S_ERROR));
    assign asm_en  = xfer && (state == S_DATA);

    byte_assembler #(.WORD_W(WORD_W)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (restart),
        .en         (asm_en),
        .din        (in_data),
        .idx        (asm_idx),
        .word       (asm_word),
        .word_valid (asm_vld)
    );

    // The assembler's registered word strobe is the memory write itself.
    assign mem_we    = asm_vld;
    assign mem_wdata = asm_word;
    assign mem_addr  = wcnt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_CNT_HI;
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cnt_hi    <= '0;
            n_words   <= '0;
            wcnt      <= '0;
            xsum      <= '0;
        end else begin
            in_ready <= is_loading(state);
            if (asm_vld) begin
                wcnt <= wcnt + 1'b1;
            end
            case (state)
                S_CNT_HI: if (xfer) begin
                    cnt_hi <= in_data;
                    xsum   <= xsum ^ in_data;
                    state  <= S_CNT_LO;
                end
                S_CNT_LO: if (xfer) begin
                    n_words <= {cnt_hi, in_data};
                    xsum    <= xsum ^ in_data;
                    if (32'({cnt_hi, in_data}) > CAP) begin
                        state    <= S_ERROR;
                        in_ready <= 1'b0;
                    end else if ({cnt_hi, in_data} == 16'd0) begin
                        state <= S_CHECK;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
                    xsum <= xsum ^ in_data;
                    // wcnt has not yet counted the word completing on this byte.
                    if ((asm_idx == 2'(BYTES_PER_WORD - 1)) &&
                        (32'(wcnt) + 32'd1 == 32'(n_words))) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: if (xfer) begin
                    in_ready <= 1'b0;
                    state    <= (in_data == xsum) ? S_DONE : S_ERROR;
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_CNT_HI;
                        in_ready  <= 1'b1;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        wcnt      <= '0;
                        xsum      <= '0;
                    end else if (state == S_DONE) begin
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        error     <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                end
                default: state <= S_CNT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed loads plus random streams checked against a stream-level model.
module tb_instr_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 2 ** ADDR_W;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'h00;
    logic              start = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    instr_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    wr_t  got_w[$];
    wr_t  exp_w[$];
    int   wide_cnt = 0;
    logic prev_we  = 1'b0;
    logic exp_done;
    logic exp_err;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Write monitor: logs every strobe and counts strobes longer than one cycle.
    always @(negedge clk) begin
        if (mem_we) got_w.push_back(wr_t'{addr: mem_addr, data: mem_wdata});
        if (mem_we && prev_we) wide_cnt++;
        prev_we = mem_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what a stream should produce, from the stream format alone.
    task automatic model(input bq_t s);
        int         n;
        logic [7:0] x;
        exp_w.delete();
        n = int'({s[0], s[1]});
        if (n > CAP) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 4 * n + 2; i++) x ^= s[i];
        for (int w = 0; w < n; w++)
            exp_w.push_back(wr_t'{addr: ADDR_W'(w),
                                  data: {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]}});
        exp_done = (s[4 * n + 2] == x);
        exp_err  = !exp_done;
    endtask

    // gap < 0 picks a random 0..3 idle cycles before each byte.
    task automatic send(input bq_t s, input int gap);
        int tmo;
        for (int i = 0; i < s.size(); i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            tmo = 0;
            while (!in_ready && tmo < 50) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 50) begin
                chk("ready_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input bq_t s, input int gap);
        int tmo;
        got_w.delete();
        wide_cnt = 0;
        model(s);
        send(s, gap);
        chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        tmo = 0;
        while (!(done || error) && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
        chk({tag, "_nwrites"}, 64'(got_w.size()), 64'(exp_w.size()));
        chk({tag, "_we_width"}, 64'(wide_cnt), 64'd0);
        if (got_w.size() == exp_w.size())
            for (int i = 0; i < exp_w.size(); i++)
                chk($sformatf("%s_wr%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
    endtask

    task automatic restart(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_rs_cpu_reset"}, 64'(cpu_reset), 64'd1);
        chk({tag, "_rs_done"}, 64'(done), 64'd0);
        chk({tag, "_rs_error"}, 64'(error), 64'd0);
        chk({tag, "_rs_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_rs_addr"}, 64'(mem_addr), 64'd0);
    endtask

    initial begin
        bq_t        s;
        bq_t        basic;
        int         n;
        logic [7:0] x;
        logic [7:0] v;

        basic = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};

        // Reset values
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_ready_first", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rel_ready_after", 64'(in_ready), 64'd1);

        run_load("basic", basic, 0);
        restart("basic");

        s = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
        run_load("badsum", s, 0);
        restart("badsum");

        s = '{8'h00, 8'h00, 8'h00};
        run_load("empty", s, 0);
        restart("empty");

        s = '{8'h01, 8'h01};
        run_load("ovf", s, 0);
        restart("ovf");

        run_load("bp", basic, 3);
        restart("bp");

        // Abort mid-word with reset, then reload
        got_w.delete();
        s = '{8'h00, 8'h01, 8'h20, 8'h08};
        send(s, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_nwrites", 64'(got_w.size()), 64'd0);
        chk("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("abort_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        run_load("reload", basic, 0);
        restart("reload");

        // Full-capacity load
        s.delete();
        s.push_back(8'(CAP >> 8));
        s.push_back(8'(CAP));
        x = s[0] ^ s[1];
        for (int i = 0; i < 4 * CAP; i++) begin
            v = 8'($urandom);
            s.push_back(v);
            x ^= v;
        end
        s.push_back(x);
        run_load("full", s, 0);
        restart("full");

        // Random streams, some with corrupted checksums or oversized counts
        for (int it = 0; it < 8; it++) begin
            s.delete();
            if ($urandom_range(7, 0) == 0) begin
                n = int'($urandom_range(65535, CAP + 1));
                s.push_back(8'(n >> 8));
                s.push_back(8'(n));
            end else begin
                n = int'($urandom_range(5, 0));
                s.push_back(8'(n >> 8));
                s.push_back(8'(n));
                x = s[0] ^ s[1];
                for (int i = 0; i < 4 * n; i++) begin
                    v = 8'($urandom);
                    s.push_back(v);
                    x ^= v;
                end
                if ($urandom_range(2, 0) == 0) x ^= 8'($urandom_range(255, 1));
                s.push_back(x);
            end
            run_load($sformatf("rnd%0d", it), s, -1);
            restart($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
